// File: rtl/wb_commit_stage_if.sv
// ============================================================================
// Module      : wb_commit_stage_if
// Description : Bundle of handshake, regfile-write, forwarding and status
//               signals for the writeback/commit stage.
//               slave  modport : the commit stage itself
//               master modport : upstream pipeline / regfile side
//               Upstream inputs : in_valid, in_src_data, in_sel, in_rd_ena,
//                                 in_rd_addr, in_pc, in_inst, wb_stall
//               Stage outputs   : in_ready, wb_rd_ena, wb_rd_addr, wb_data,
//                                 fwd_valid, fwd_rd_addr, fwd_rd_data,
//                                 retire_cnt, halt
//                                 (+ trace_valid, trace_pc, trace_inst when
//                                  WB_COMMIT_TRACE_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface wb_commit_stage_if #(
    parameter int XLEN   = 64,
    parameter int NSRC   = 3,
    parameter int SEL_W  = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NSRC*XLEN-1:0]   in_src_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_rd_ena;
    logic [REG_AW-1:0]      in_rd_addr;
    logic [63:0]            in_pc;
    logic [31:0]            in_inst;
    logic                   wb_stall;
    logic                   wb_rd_ena;
    logic [REG_AW-1:0]      wb_rd_addr;
    logic [XLEN-1:0]        wb_data;
    logic                   fwd_valid;
    logic [REG_AW-1:0]      fwd_rd_addr;
    logic [XLEN-1:0]        fwd_rd_data;
    logic [CNT_W-1:0]       retire_cnt;
    logic                   halt;
`ifdef WB_COMMIT_TRACE_EN
    logic                   trace_valid;
    logic [63:0]            trace_pc;
    logic [31:0]            trace_inst;
`endif

    modport slave (
        input  in_valid, in_src_data, in_sel, in_rd_ena, in_rd_addr,
               in_pc, in_inst, wb_stall,
`ifdef WB_COMMIT_TRACE_EN
        output trace_valid, trace_pc, trace_inst,
`endif
        output in_ready, wb_rd_ena, wb_rd_addr, wb_data, fwd_valid,
               fwd_rd_addr, fwd_rd_data, retire_cnt, halt
    );

    modport master (
        output in_valid, in_src_data, in_sel, in_rd_ena, in_rd_addr,
               in_pc, in_inst, wb_stall,
`ifdef WB_COMMIT_TRACE_EN
        input  trace_valid, trace_pc, trace_inst,
`endif
        input  in_ready, wb_rd_ena, wb_rd_addr, wb_data, fwd_valid,
               fwd_rd_addr, fwd_rd_data, retire_cnt, halt
    );
endinterface

`default_nettype wire

// File: rtl/wb_commit_stage.sv
// ============================================================================
// Module      : wb_commit_stage
// Description : Writeback/commit stage. Selects one of NSRC result sources at
//               enqueue, buffers entries in a DEPTH-entry in-order FIFO and
//               retires them to the register file under wb_stall
//               back-pressure. Provides rd forwarding from the FIFO head, a
//               retired-instruction counter and an ebreak halt FSM.
//               Ports : clk, rst (async active-low), bus (wb_commit_stage_if
//                       slave modport, see interface header for members).
//               Optional feature macro WB_COMMIT_TRACE_EN adds per-entry PC
//               storage and trace_valid/trace_pc/trace_inst outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_commit_stage #(
    parameter int XLEN   = 64,
    parameter int NSRC   = 3,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_stage_if.slave  bus
);
    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);
    localparam logic [31:0]        c_EBREAK    = 32'h00100073;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // FIFO storage (no reset needed: every read is qualified by r_count)
    logic [XLEN-1:0]    r_data    [DEPTH];
    logic [REG_AW-1:0]  r_rd_addr [DEPTH];
    logic [31:0]        r_inst    [DEPTH];
    logic [DEPTH-1:0]   r_rd_ena;
`ifdef WB_COMMIT_TRACE_EN
    logic [63:0]        r_pc      [DEPTH];
`endif

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [CNT_W-1:0]   r_retire_cnt;
    state_t             r_state;
    logic               r_halt;

    logic               w_not_empty;
    logic               w_run;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_head_rd_ena;
    logic [REG_AW-1:0]  w_head_addr;
    logic [XLEN-1:0]    w_head_data;
    logic [XLEN-1:0]    w_sel_data;

    assign w_not_empty = (r_count != '0);
    assign w_run       = (r_state == S_RUN);
    // No full-bypass: a pop in the same cycle does not open a slot early.
    assign w_in_ready  = (r_count < c_DEPTH_CNT) & w_run;
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_not_empty & ~bus.wb_stall & w_run;

    // Head view is forced to zero when empty so outputs never show stale data.
    assign w_head_rd_ena = w_not_empty & r_rd_ena[r_rd_ptr];
    assign w_head_addr   = w_not_empty ? r_rd_addr[r_rd_ptr] : '0;
    assign w_head_data   = w_not_empty ? r_data[r_rd_ptr]    : '0;

    // Source mux; select values without a matching source yield zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                w_sel_data = bus.in_src_data[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr]    <= w_sel_data;
            r_rd_addr[r_wr_ptr] <= bus.in_rd_addr;
            r_inst[r_wr_ptr]    <= bus.in_inst;
            // Writes to x0 are dropped here so neither retire nor forward sees them.
            r_rd_ena[r_wr_ptr]  <= bus.in_rd_ena & (bus.in_rd_addr != '0);
`ifdef WB_COMMIT_TRACE_EN
            r_pc[r_wr_ptr]      <= bus.in_pc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Halt FSM: the ebreak itself retires on the transition edge; afterwards
    // the FIFO is frozen until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_pop && (r_inst[r_rd_ptr] == c_EBREAK)) begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.wb_rd_ena   = w_pop & w_head_rd_ena;
    assign bus.wb_rd_addr  = w_head_addr;
    assign bus.wb_data     = w_head_data;
    assign bus.fwd_valid   = w_head_rd_ena;
    assign bus.fwd_rd_addr = w_head_addr;
    assign bus.fwd_rd_data = w_head_data;
    assign bus.retire_cnt  = r_retire_cnt;
    assign bus.halt        = r_halt;

`ifdef WB_COMMIT_TRACE_EN
    assign bus.trace_valid = w_pop;
    assign bus.trace_pc    = w_not_empty ? r_pc[r_rd_ptr]   : '0;
    assign bus.trace_inst  = w_not_empty ? r_inst[r_rd_ptr] : '0;
`else
    // The PC is only needed for trace output.
    logic w_unused_pc;
    assign w_unused_pc = ^bus.in_pc;
`endif

endmodule

`default_nettype wire
